// File: rtl/pa_fpu.sv
// Shared definitions for the FPU command sequencer: sequencer states, FPU register map and opcodes.
package pa_fpu;

  typedef enum logic [3:0] {
    StIdle,
    StBusyChk,
    StWrA,
    StWrB,
    StWrOp,
    StWaitEnd,
    StRdRes,
    StAck,
    StOut
  } fpu_seq_state_t;

  localparam logic [5:0] FPU_ADDR_OPA = 6'h00;
  localparam logic [5:0] FPU_ADDR_OPB = 6'h04;
  localparam logic [5:0] FPU_ADDR_OP  = 6'h08;

  localparam logic [7:0] op_add = 8'h00;
  localparam logic [7:0] op_sub = 8'h01;
  localparam logic [7:0] op_mul = 8'h02;
  localparam logic [7:0] op_div = 8'h03;

  // Quiet NaN returned when the FPU never signals completion.
  localparam logic [31:0] FPU_QNAN = 32'h7FC0_0000;

endpackage

// File: rtl/fpu_bus_access.sv
// Single-byte FPU bus cycle engine: setup clock, STROBE_CYC strobe clocks, recovery clock.
// A new start is accepted while idle or during the recovery clock of the previous access.
module fpu_bus_access #(
  parameter int unsigned STROBE_CYC = 1
) (
  input  logic       clk,
  input  logic       arst,
  input  logic       start,
  input  logic       we,
  input  logic [5:0] addr,
  input  logic [7:0] wdata,
  output logic       ready,
  output logic       done,
  output logic [7:0] rdata,
  input  logic [7:0] fpu_data_i,
  output logic [7:0] fpu_data_o,
  output logic [5:0] fpu_addr,
  output logic       fpu_cs,
  output logic       fpu_rd,
  output logic       fpu_wr
);

  localparam logic [1:0] PhIdle   = 2'd0;
  localparam logic [1:0] PhSetup  = 2'd1;
  localparam logic [1:0] PhStrobe = 2'd2;
  localparam logic [1:0] PhRecov  = 2'd3;

  localparam int unsigned CntW = (STROBE_CYC > 1) ? $clog2(STROBE_CYC) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(STROBE_CYC - 1);

  logic [1:0]      phase_q, phase_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [5:0]      addr_q, addr_d;
  logic [7:0]      data_q, data_d;
  logic            cs_q, cs_d, rd_q, rd_d, wr_q, wr_d;

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cs_d    = 1'b1;
    rd_d    = 1'b1;
    wr_d    = 1'b1;
    case (phase_q)
      PhSetup: begin
        phase_d = PhStrobe;
        cnt_d   = '0;
        cs_d    = 1'b0;
        rd_d    = we_q;
        wr_d    = ~we_q;
      end
      PhStrobe: begin
        if (cnt_q == CntLast) begin
          phase_d = PhRecov;
        end else begin
          cnt_d = cnt_q + 1'b1;
          cs_d  = 1'b0;
          rd_d  = we_q;
          wr_d  = ~we_q;
        end
      end
      default: begin
        phase_d = PhIdle;
        if (start) begin
          phase_d = PhSetup;
          cs_d    = 1'b0;
          we_d    = we;
          addr_d  = addr;
          data_d  = we ? wdata : 8'h00;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      phase_q <= PhIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= 6'h00;
      data_q  <= 8'h00;
      cs_q    <= 1'b1;
      rd_q    <= 1'b1;
      wr_q    <= 1'b1;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cs_q    <= cs_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  assign ready      = (phase_q == PhIdle) || (phase_q == PhRecov);
  // Read data is taken by the caller on the last strobe clock.
  assign done       = (phase_q == PhStrobe) && (cnt_q == CntLast);
  assign rdata      = fpu_data_i;
  assign fpu_data_o = data_q;
  assign fpu_addr   = addr_q;
  assign fpu_cs     = cs_q;
  assign fpu_rd     = rd_q;
  assign fpu_wr     = wr_q;

endmodule

// File: rtl/fpu_cmd_sequencer.sv
// Host-side FPU driver: writes operands/opcode, waits for cmd_end, reads and returns the result.
// Defining FPU_SEQ_TIMEOUT_EN adds a WAIT_END watchdog that returns a quiet NaN with res_err.
module fpu_cmd_sequencer
  import pa_fpu::*;
#(
  parameter int unsigned STROBE_CYC  = 1,
  parameter logic [5:0]  RES_ADDR    = 6'h09,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_op_a,
  input  logic [31:0] cmd_op_b,
  input  logic [7:0]  cmd_opcode,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_err,
  output logic [7:0]  fpu_data_o,
  input  logic [7:0]  fpu_data_i,
  output logic [5:0]  fpu_addr,
  output logic        fpu_cs,
  output logic        fpu_rd,
  output logic        fpu_wr,
  output logic        fpu_end_ack,
  input  logic        fpu_cmd_end,
  input  logic        fpu_busy
);

  fpu_seq_state_t state_q, state_d;
  logic [1:0]     idx_q, idx_d;
  logic [31:0]    op_a_q, op_a_d, op_b_q, op_b_d, res_q, res_d;
  logic [7:0]     opc_q, opc_d;
  logic           err_q, err_d, end_ack_q, end_ack_d;
  logic           acc_start, acc_we, acc_ready, acc_done;
  logic [5:0]     acc_addr;
  logic [7:0]     acc_wdata, acc_rdata;
  logic           timeout;

`ifdef FPU_SEQ_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYC + 1);
  logic [WdW-1:0] wd_q, wd_d;

  always_comb begin
    wd_d = wd_q;
    if (state_q == StIdle) wd_d = '0;
    else if (state_q == StWaitEnd && !fpu_cmd_end) wd_d = wd_q + 1'b1;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) wd_q <= '0;
    else      wd_q <= wd_d;
  end

  assign timeout = (state_q == StWaitEnd) && !fpu_cmd_end && (wd_q == WdW'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
  assign timeout            = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    opc_d     = opc_q;
    res_d     = res_q;
    err_d     = err_q;
    acc_start = 1'b0;
    acc_we    = 1'b1;
    acc_addr  = FPU_ADDR_OPA + {4'b0, idx_q};
    acc_wdata = op_a_q[{idx_q, 3'b000} +: 8];
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          op_a_d  = cmd_op_a;
          op_b_d  = cmd_op_b;
          opc_d   = cmd_opcode;
          idx_d   = 2'd0;
          err_d   = 1'b0;
          state_d = StBusyChk;
        end
      end
      // Byte 0 of A is launched straight from here to save a clock.
      StBusyChk: begin
        if (!fpu_busy) begin
          acc_start = 1'b1;
          state_d   = StWrA;
        end
      end
      StWrA: begin
        acc_start = acc_ready;
        if (acc_done) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = StWrB;
        end
      end
      StWrB: begin
        acc_addr  = FPU_ADDR_OPB + {4'b0, idx_q};
        acc_wdata = op_b_q[{idx_q, 3'b000} +: 8];
        acc_start = acc_ready;
        if (acc_done) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = StWrOp;
        end
      end
      StWrOp: begin
        acc_addr  = FPU_ADDR_OP;
        acc_wdata = opc_q;
        acc_start = acc_ready;
        if (acc_done) state_d = StWaitEnd;
      end
      StWaitEnd: begin
        if (fpu_cmd_end) begin
          state_d = StRdRes;
        end else if (timeout) begin
          res_d   = FPU_QNAN;
          err_d   = 1'b1;
          state_d = StOut;
        end
      end
      // Result bytes arrive LSB first and are shifted in from the top.
      StRdRes: begin
        acc_we    = 1'b0;
        acc_addr  = RES_ADDR + {4'b0, idx_q};
        acc_wdata = 8'h00;
        acc_start = acc_ready;
        if (acc_done) begin
          res_d = {acc_rdata, res_q[31:8]};
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = StAck;
        end
      end
      StAck: begin
        if (!fpu_cmd_end) state_d = StOut;
      end
      StOut: begin
        if (res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    end_ack_d = (state_d == StAck);
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q   <= StIdle;
      idx_q     <= 2'd0;
      op_a_q    <= 32'h0;
      op_b_q    <= 32'h0;
      opc_q     <= 8'h0;
      res_q     <= 32'h0;
      err_q     <= 1'b0;
      end_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      opc_q     <= opc_d;
      res_q     <= res_d;
      err_q     <= err_d;
      end_ack_q <= end_ack_d;
    end
  end

  fpu_bus_access #(
    .STROBE_CYC(STROBE_CYC)
  ) u_bus (
    .clk       (clk),
    .arst      (arst),
    .start     (acc_start),
    .we        (acc_we),
    .addr      (acc_addr),
    .wdata     (acc_wdata),
    .ready     (acc_ready),
    .done      (acc_done),
    .rdata     (acc_rdata),
    .fpu_data_i(fpu_data_i),
    .fpu_data_o(fpu_data_o),
    .fpu_addr  (fpu_addr),
    .fpu_cs    (fpu_cs),
    .fpu_rd    (fpu_rd),
    .fpu_wr    (fpu_wr)
  );

  assign cmd_ready   = (state_q == StIdle);
  assign res_valid   = (state_q == StOut);
  assign res_data    = res_q;
  assign res_err     = err_q;
  assign fpu_end_ack = end_ack_q;

endmodule

// File: tb/tb_fpu_cmd_sequencer.sv
// Bench for fpu_cmd_sequencer: a behavioural FPU slave plus directed and random commands.
// Defining FPU_SEQ_TIMEOUT_EN also exercises the WAIT_END watchdog.
module tb_fpu_cmd_sequencer;
  import pa_fpu::*;

  localparam int TMO = 16;

  logic        clk, arst;
  logic        cmd_valid, cmd_ready, res_valid, res_ready, res_err;
  logic [31:0] cmd_op_a, cmd_op_b, res_data;
  logic [7:0]  cmd_opcode, fpu_data_o, fpu_data_i;
  logic [5:0]  fpu_addr, roff;
  logic        fpu_cs, fpu_rd, fpu_wr, fpu_end_ack, fpu_cmd_end, fpu_busy;

  logic [31:0] fpu_res;
  logic [13:0] wlog[$];
  int          cyc, op_cyc, rd_cyc, rd_cnt, cs_low;
  int          n_pass, n_fail, n_total;

  fpu_cmd_sequencer #(
    .STROBE_CYC (1),
    .RES_ADDR   (6'h09),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk        (clk),
    .arst       (arst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op_a   (cmd_op_a),
    .cmd_op_b   (cmd_op_b),
    .cmd_opcode (cmd_opcode),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_err    (res_err),
    .fpu_data_o (fpu_data_o),
    .fpu_data_i (fpu_data_i),
    .fpu_addr   (fpu_addr),
    .fpu_cs     (fpu_cs),
    .fpu_rd     (fpu_rd),
    .fpu_wr     (fpu_wr),
    .fpu_end_ack(fpu_end_ack),
    .fpu_cmd_end(fpu_cmd_end),
    .fpu_busy   (fpu_busy)
  );

  // FPU result registers live at 0x09..0x0C, byte 0 = LSB.
  assign roff       = fpu_addr - 6'h09;
  assign fpu_data_i = (roff < 6'd4) ? 8'(fpu_res >> (8 * roff)) : 8'hEE;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Bus monitor: samples mid-cycle; *_cyc values name the clock edge that ends the strobe.
  initial begin : monitor
    logic wr_prev, rd_prev;
    wr_prev = 1'b1;
    rd_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!fpu_cs && !fpu_wr && wr_prev) wlog.push_back({fpu_addr, fpu_data_o});
      if (!fpu_cs && !fpu_wr && fpu_addr == FPU_ADDR_OP) op_cyc = cyc + 1;
      if (!fpu_cs && !fpu_rd && rd_prev) begin
        rd_cnt++;
        if (rd_cyc < 0) rd_cyc = cyc + 1;
      end
      if (!fpu_cs) cs_low++;
      wr_prev = fpu_wr;
      rd_prev = fpu_rd;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed hang expected $finish");
    $fatal(1, "simulation time limit");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // lat < 0: cmd_end already high before WAIT_END; hang: FPU never completes.
  task automatic run_cmd(input logic [31:0] a, input logic [31:0] b, input logic [7:0] opc,
                         input logic [31:0] r, input int lat, input int busy_cyc,
                         input int stall, input bit hang);
    int          acc, t, bad, cs_at_out;
    logic [31:0] first, exp_res;
    logic [13:0] exp_w[$];
    for (int i = 0; i < 4; i++) exp_w.push_back({6'(i), 8'((a >> (8 * i)) & 32'hFF)});
    for (int i = 0; i < 4; i++) exp_w.push_back({6'(4 + i), 8'((b >> (8 * i)) & 32'hFF)});
    exp_w.push_back({6'd8, opc});
    exp_res = hang ? 32'h7FC0_0000 : r;

    fpu_res = r;
    fpu_busy = (busy_cyc > 0);
    fpu_cmd_end = 1'b0;
    wlog.delete();
    rd_cnt = 0;
    cs_low = 0;
    op_cyc = -1;
    rd_cyc = -1;
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_op_a = a;
    cmd_op_b = b;
    cmd_opcode = opc;
    cmd_valid = 1'b1;
    tick();
    acc = cyc;
    cmd_valid = 1'b0;
    cmd_op_a = $urandom;
    cmd_op_b = $urandom;
    cmd_opcode = 8'($urandom);
    check("cmd_ready_busy", cmd_ready, 0);
    if (busy_cyc > 0) begin
      repeat (busy_cyc) tick();
      check("no_cs_while_busy", {31'd0, fpu_cs} + 32'(cs_low), 1);
      fpu_busy = 1'b0;
    end
    if (lat < 0) fpu_cmd_end = 1'b1;
    t = 0;
    while (op_cyc < 0 && t < 200) begin
      tick();
      t++;
    end
    check("op_written", op_cyc >= 0, 1);
    if (busy_cyc == 0) check("accept_to_wrop_end", op_cyc - acc, 27);
    fpu_busy = 1'b1;
    if (!hang) begin
      if (lat > 0) repeat (lat) tick();
      fpu_cmd_end = 1'b1;
      t = 0;
      while (!fpu_end_ack && t < 200) begin
        tick();
        t++;
      end
      check("end_ack_rise", fpu_end_ack, 1);
      if (lat <= 0) check("rd_start_latency", rd_cyc - op_cyc, 4);
      repeat (3) tick();
      check("end_ack_hold", fpu_end_ack, 1);
      check("no_res_during_ack", res_valid, 0);
      fpu_cmd_end = 1'b0;
    end
    t = 0;
    while (!res_valid && t < 300) begin
      tick();
      t++;
    end
    check("res_valid", res_valid, 1);
    if (hang) check("timeout_delay", cyc - op_cyc, TMO);
    check("res_data", res_data, exp_res);
    check("res_err", res_err, hang);
    check("end_ack_low", fpu_end_ack, 0);
    check("read_count", rd_cnt, hang ? 0 : 4);
    check("write_count", wlog.size(), 9);
    bad = 0;
    for (int i = 0; i < 9; i++) if (i >= wlog.size() || wlog[i] !== exp_w[i]) bad++;
    check("write_sequence", bad, 0);
    first = res_data;
    cs_at_out = cs_low;
    bad = 0;
    res_ready = 1'b0;
    repeat (stall) begin
      tick();
      if (res_valid !== 1'b1 || res_data !== first || cmd_ready !== 1'b0 || fpu_cs !== 1'b1)
        bad++;
    end
    check("out_stable", bad, 0);
    check("no_bus_in_out", cs_low - cs_at_out, 0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("idle_after_take", {cmd_ready, res_valid}, 2'b10);
    fpu_busy = 1'b0;
  endtask

  initial begin
    int t;
    n_pass = 0;
    n_fail = 0;
    n_total = 0;
    arst = 1'b1;
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    cmd_op_a = '0;
    cmd_op_b = '0;
    cmd_opcode = '0;
    fpu_cmd_end = 1'b0;
    fpu_busy = 1'b0;
    fpu_res = '0;
    repeat (3) tick();
    check("rst_strobes", {fpu_cs, fpu_rd, fpu_wr}, 3'b111);
    check("rst_outs", {fpu_end_ack, res_valid, res_err, cmd_ready}, 4'b0001);
    check("rst_bus", {fpu_addr, fpu_data_o}, 0);
    check("rst_res_data", res_data, 0);
    arst = 1'b0;
    tick();

    run_cmd(32'hc080_0000, 32'hc0c0_0000, op_add, 32'hc120_0000, 0, 0, 2, 1'b0);
    run_cmd(32'h3f80_0000, 32'h4000_0000, op_mul, 32'h4000_0000, 3, 20, 1, 1'b0);
    run_cmd(32'h4120_0000, 32'h3f00_0000, op_sub, 32'h4118_0000, 2, 0, 50, 1'b0);
    run_cmd(32'h1234_5678, 32'h9abc_def0, op_div, 32'h0bad_f00d, -1, 0, 0, 1'b0);
    for (int n = 0; n < 4; n++)
      run_cmd($urandom, $urandom, 8'($urandom_range(0, 3)), $urandom,
              $urandom_range(0, 8), ($urandom_range(0, 1) == 1) ? $urandom_range(1, 6) : 0,
              $urandom_range(0, 4), 1'b0);

    // Abort during operand B byte 2, then confirm a clean command afterwards.
    cmd_op_a = 32'hdead_beef;
    cmd_op_b = 32'h0102_0304;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    t = 0;
    while (!(!fpu_cs && !fpu_wr && fpu_addr == 6'h06) && t < 100) begin
      tick();
      t++;
    end
    check("reached_wrb_byte2", fpu_addr, 6'h06);
    arst = 1'b1;
    #1;
    check("abort_strobes", {fpu_cs, fpu_rd, fpu_wr}, 3'b111);
    check("abort_outs", {fpu_end_ack, res_valid, cmd_ready}, 3'b001);
    tick();
    arst = 1'b0;
    tick();
    run_cmd($urandom, $urandom, op_add, $urandom, 1, 0, 1, 1'b0);

`ifdef FPU_SEQ_TIMEOUT_EN
    run_cmd(32'h4040_0000, 32'h4080_0000, op_add, 32'h40e0_0000, 0, 0, 2, 1'b1);
    run_cmd(32'h4040_0000, 32'h4080_0000, op_add, 32'h40e0_0000, 2, 0, 1, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
